// File: rtl/hdmi_line_buffer_pkg.sv
// hdmi_line_buffer_pkg: shared video defaults, RGB field offsets and FSM state types.
package hdmi_line_buffer_pkg;
   localparam int          H_ACTIVE_DEF = 720;
   localparam int          X_W_DEF      = 10;
   localparam logic [23:0] BG_COLOR_DEF = 24'h000000;
   localparam int          R_LSB        = 16;
   localparam int          G_LSB        = 8;
   localparam int          B_LSB        = 0;
   typedef enum logic {FILL, DROP} wr_state_e;
   typedef enum logic {IDLE, LINE} rd_state_e;
endpackage

// File: rtl/hdmi_line_buffer_dpram.sv
// hdmi_line_buffer_dpram: simple dual-port RAM, sync write port and registered read port.
module hdmi_line_buffer_dpram #(
   parameter int AW = 11,
   parameter int DW = 24
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);
   logic [DW-1:0] mem_q [2**AW];
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
   end
endmodule

// File: rtl/hdmi_line_buffer.sv
// hdmi_line_buffer: ping-pong RGB line buffer between a pixel producer and the TMDS encoders.
module hdmi_line_buffer
   import hdmi_line_buffer_pkg::*;
#(
   parameter int          H_ACTIVE = H_ACTIVE_DEF,
   parameter int          X_W      = X_W_DEF,
   parameter logic [23:0] BG_COLOR = BG_COLOR_DEF
) (
   input  logic           clk_pixel,
   input  logic           rst_n,
   input  logic           wr_valid,
   output logic           wr_ready,
   input  logic [23:0]    wr_data,
   input  logic           wr_last,
   input  logic           video_active,
   input  logic           hsync,
   input  logic           vsync,
   input  logic [X_W-1:0] pixel_x,
   output logic [7:0]     red,
   output logic [7:0]     green,
   output logic [7:0]     blue,
   output logic           de_out,
   output logic           hsync_out,
   output logic           vsync_out,
   output logic           underrun,
   output logic           overflow,
   input  logic           clr_status
);
   logic [1:0]        full_q, full_d;
   logic [1:0][X_W:0] len_q, len_d;
   logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic [X_W-1:0]    wr_addr_q, wr_addr_d;
   wr_state_e         wr_st_q, wr_st_d;
   rd_state_e         rd_st_q, rd_st_d;
   logic              de_q, hs_q, vs_q, sel_q, sel_d;
   logic              underrun_q, underrun_d, overflow_q, overflow_d;
   logic              we, at_end, wr_done, line_start, line_end, ok_now;
   logic [23:0]       ram_q, rgb;

   assign wr_ready   = rst_n & (wr_st_q == DROP | ~full_q[wr_bank_q]);
   assign we         = wr_valid & wr_ready & (wr_st_q == FILL);
   assign at_end     = wr_addr_q == X_W'(H_ACTIVE - 1);
   assign wr_done    = we & (wr_last | at_end);
   assign line_start = video_active & ~de_q;
   assign line_end   = ~video_active & de_q;
   // the first pixel of a line sees full[] directly since line_ok is only being loaded
   assign ok_now     = line_start ? full_q[rd_bank_q] : rd_st_q == LINE;

   always_comb begin
      full_d     = full_q;
      len_d      = len_q;
      wr_bank_d  = wr_bank_q;
      wr_addr_d  = wr_addr_q;
      wr_st_d    = wr_st_q;
      rd_bank_d  = rd_bank_q;
      rd_st_d    = rd_st_q;
      underrun_d = underrun_q & ~clr_status;
      overflow_d = overflow_q & ~clr_status;
      if (we) wr_addr_d = wr_addr_q + 1'b1;
      if (wr_done) begin
         full_d[wr_bank_q] = 1'b1;
         len_d[wr_bank_q]  = {1'b0, wr_addr_q} + 1'b1;
         wr_addr_d         = '0;
         wr_bank_d         = ~wr_bank_q;
      end
      if (we & at_end & ~wr_last) begin
         wr_st_d    = DROP;
         overflow_d = 1'b1;
      end
      if (wr_valid & wr_ready & wr_st_q == DROP & wr_last) wr_st_d = FILL;
      if (line_start) begin
         rd_st_d = full_q[rd_bank_q] ? LINE : IDLE;
         if (!full_q[rd_bank_q]) underrun_d = 1'b1;
      end
      if (line_end) begin
         if (rd_st_q == LINE) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
         end
         rd_st_d = IDLE;
      end
      sel_d = video_active & ok_now & ({1'b0, pixel_x} < len_q[rd_bank_q]);
   end

   always_ff @(posedge clk_pixel) begin
      if (!rst_n) begin
         full_q     <= '0;
         len_q      <= '0;
         wr_bank_q  <= 1'b0;
         wr_addr_q  <= '0;
         wr_st_q    <= FILL;
         rd_bank_q  <= 1'b0;
         rd_st_q    <= IDLE;
         de_q       <= 1'b0;
         hs_q       <= 1'b0;
         vs_q       <= 1'b0;
         sel_q      <= 1'b0;
         underrun_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         full_q     <= full_d;
         len_q      <= len_d;
         wr_bank_q  <= wr_bank_d;
         wr_addr_q  <= wr_addr_d;
         wr_st_q    <= wr_st_d;
         rd_bank_q  <= rd_bank_d;
         rd_st_q    <= rd_st_d;
         de_q       <= video_active;
         hs_q       <= hsync;
         vs_q       <= vsync;
         sel_q      <= sel_d;
         underrun_q <= underrun_d;
         overflow_q <= overflow_d;
      end
   end

   hdmi_line_buffer_dpram #(.AW(X_W + 1), .DW(24)) u_ram (
      .clk_i   (clk_pixel),
      .we_i    (we),
      .waddr_i ({wr_bank_q, wr_addr_q}),
      .wdata_i (wr_data),
      .raddr_i ({rd_bank_q, pixel_x}),
      .rdata_o (ram_q)
   );

   // RAM read register sets the latency; select and sideband are registered alongside it
   assign rgb       = de_q ? (sel_q ? ram_q : BG_COLOR) : '0;
   assign red       = rgb[R_LSB +: 8];
   assign green     = rgb[G_LSB +: 8];
   assign blue      = rgb[B_LSB +: 8];
   assign de_out    = de_q;
   assign hsync_out = hs_q;
   assign vsync_out = vs_q;
   assign underrun  = underrun_q;
   assign overflow  = overflow_q;
endmodule

// File: tb/tb_hdmi_line_buffer.sv
// tb_hdmi_line_buffer: directed scenario bench for the ping-pong HDMI line buffer.
module tb_hdmi_line_buffer;
   localparam int          H  = 720;
   localparam logic [23:0] BG = 24'h123456;

   logic        clk_pixel = 1'b0, rst_n = 1'b0;
   logic        wr_valid = 1'b0, wr_last = 1'b0, wr_ready;
   logic [23:0] wr_data = '0;
   logic        video_active = 1'b0, hsync = 1'b0, vsync = 1'b0, clr_status = 1'b0;
   logic [9:0]  pixel_x = '0;
   logic [7:0]  red, green, blue;
   logic        de_out, hsync_out, vsync_out, underrun, overflow;
   int          n_checks = 0, n_fail = 0;

   always #5 clk_pixel = ~clk_pixel;

   hdmi_line_buffer #(.H_ACTIVE(H), .X_W(10), .BG_COLOR(BG)) dut (
      .clk_pixel    (clk_pixel),
      .rst_n        (rst_n),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .wr_last      (wr_last),
      .video_active (video_active),
      .hsync        (hsync),
      .vsync        (vsync),
      .pixel_x      (pixel_x),
      .red          (red),
      .green        (green),
      .blue         (blue),
      .de_out       (de_out),
      .hsync_out    (hsync_out),
      .vsync_out    (vsync_out),
      .underrun     (underrun),
      .overflow     (overflow),
      .clr_status   (clr_status)
   );

   task automatic cyc();
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic write_line(input int n, input logic [23:0] base, input int stall_pct, output int waits);
      waits = 0;
      for (int i = 0; i < n; i++) begin
         while (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) begin
            wr_valid = 1'b0;
            cyc();
         end
         wr_valid = 1'b1;
         wr_data  = base + 24'(i);
         wr_last  = (i == n - 1);
         while (!wr_ready && waits < 20000) begin
            waits++;
            cyc();
         end
         cyc();
      end
      wr_valid = 1'b0;
      wr_last  = 1'b0;
   endtask

   task automatic run_line(input int pre, input int len, input logic [23:0] base, input logic ok,
                           input logic clr0, output int bad, output int fx,
                           output logic [23:0] fg, output logic [23:0] fe);
      logic [23:0] e;
      bad = 0; fx = -1; fg = '0; fe = '0;
      for (int c = 0; c < pre; c++) begin
         video_active = 1'b0;
         pixel_x      = '0;
         hsync        = (c % 4) < 2;
         vsync        = (c == 0);
         cyc();
         if ({red, green, blue} !== 24'h0 || de_out !== 1'b0 || hsync_out !== hsync || vsync_out !== vsync) begin
            if (bad == 0) begin fx = -1 - c; fg = {red, green, blue}; fe = 24'h0; end
            bad++;
         end
      end
      hsync = 1'b0;
      vsync = 1'b0;
      for (int x = 0; x <= H; x++) begin
         video_active = (x < H);
         pixel_x      = (x < H) ? 10'(x) : 10'd0;
         clr_status   = clr0 && x == 0;
         cyc();
         clr_status = 1'b0;
         e = (x >= H) ? 24'h0 : (ok && x < len) ? base + 24'(x) : BG;
         if ({red, green, blue} !== e || de_out !== (x < H) || hsync_out !== 1'b0) begin
            if (bad == 0) begin fx = x; fg = {red, green, blue}; fe = e; end
            bad++;
         end
      end
      video_active = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; hsync = 1'b1; vsync = 1'b1; video_active = 1'b1; wr_valid = 1'b1;
      repeat (3) cyc();
      n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
      n_checks++; if ({red, green, blue} !== 24'h0) begin n_fail++; $display("FAIL reset_rgb: got %h expected 000000", {red, green, blue}); end
      n_checks++; if ({de_out, hsync_out, vsync_out} !== 3'b000) begin n_fail++; $display("FAIL reset_sideband: got %b expected 000", {de_out, hsync_out, vsync_out}); end
      n_checks++; if ({underrun, overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {underrun, overflow}); end
      video_active = 1'b0; hsync = 1'b0; vsync = 1'b0; wr_valid = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_wr_ready: got %b expected 1", wr_ready); end
   endtask

   task automatic test_underrun_no_data();
      int bad, fx; logic [23:0] fg, fe;
      run_line(4, 0, 24'h0, 1'b0, 1'b0, bad, fx, fg, fe);
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL empty_line_bg: %0d bad px, first x=%0d got %h expected %h", bad, fx, fg, fe); end
      n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL empty_line_underrun: got %b expected 1", underrun); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL empty_line_overflow: got %b expected 0", overflow); end
      clr_status = 1'b1; cyc(); clr_status = 1'b0;
      n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL clr_underrun: got %b expected 0", underrun); end
   endtask

   task automatic test_full_line();
      int w, bad, fx; logic [23:0] fg, fe;
      write_line(H, 24'h0, 0, w);
      n_checks++; if (w !== 0) begin n_fail++; $display("FAIL full_line_stalls: got %0d expected 0", w); end
      // bank 0 only shows data if the earlier underrun line left rd_bank at 0
      run_line(4, H, 24'h0, 1'b1, 1'b0, bad, fx, fg, fe);
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL full_line_data: %0d bad px, first x=%0d got %h expected %h", bad, fx, fg, fe); end
      n_checks++; if ({underrun, overflow} !== 2'b00) begin n_fail++; $display("FAIL full_line_flags: got %b expected 00", {underrun, overflow}); end
   endtask

   task automatic test_short_line();
      int w, bad, fx; logic [23:0] fg, fe;
      write_line(100, 24'hA00000, 0, w);
      run_line(4, 100, 24'hA00000, 1'b1, 1'b0, bad, fx, fg, fe);
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL short_line_pad: %0d bad px, first x=%0d got %h expected %h", bad, fx, fg, fe); end
   endtask

   task automatic test_overflow();
      int w, bad, fx; logic [23:0] fg, fe;
      write_line(800, 24'hB00000, 0, w);
      n_checks++; if (w !== 0) begin n_fail++; $display("FAIL overflow_ready_low: got %0d stall cycles expected 0", w); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_flag: got %b expected 1", overflow); end
      write_line(50, 24'hC00000, 0, w);
      run_line(4, H, 24'hB00000, 1'b1, 1'b0, bad, fx, fg, fe);
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL overflow_line_data: %0d bad px, first x=%0d got %h expected %h", bad, fx, fg, fe); end
      run_line(4, 50, 24'hC00000, 1'b1, 1'b0, bad, fx, fg, fe);
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL after_overflow_line: %0d bad px, first x=%0d got %h expected %h", bad, fx, fg, fe); end
      n_checks++; if ({underrun, overflow} !== 2'b01) begin n_fail++; $display("FAIL overflow_sticky: got %b expected 01", {underrun, overflow}); end
      clr_status = 1'b1; cyc(); clr_status = 1'b0;
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %b expected 0", overflow); end
   endtask

   task automatic test_back_to_back();
      int w, hi, bad, fx; logic [23:0] fg, fe;
      write_line(H, 24'hD00000, 0, w);
      write_line(200, 24'hE00000, 0, w);
      wr_valid = 1'b1; wr_data = 24'hFFFFFF; wr_last = 1'b0; hi = 0;
      repeat (5) begin
         cyc();
         if (wr_ready) hi++;
      end
      wr_valid = 1'b0;
      n_checks++; if (hi !== 0) begin n_fail++; $display("FAIL both_full_ready: got %0d ready cycles expected 0", hi); end
      run_line(4, H, 24'hD00000, 1'b1, 1'b0, bad, fx, fg, fe);
      n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_release: got %b expected 1", wr_ready); end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_line_a: %0d bad px, first x=%0d got %h expected %h", bad, fx, fg, fe); end
      run_line(4, 200, 24'hE00000, 1'b1, 1'b0, bad, fx, fg, fe);
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_line_b: %0d bad px, first x=%0d got %h expected %h", bad, fx, fg, fe); end
   endtask

   task automatic test_stalls();
      int w, tout, bad_lines, bad, fx, first_k; logic [23:0] fg, fe;
      tout = 0; bad_lines = 0; first_k = -1;
      fork
         for (int k = 0; k < 10; k++) begin
            write_line(60 + 37 * k, 24'((k + 1) << 16), 25, w);
            if (w >= 20000) tout++;
         end
         for (int j = 0; j < 10; j++) begin
            run_line(300, 60 + 37 * j, 24'((j + 1) << 16), 1'b1, 1'b0, bad, fx, fg, fe);
            if (bad != 0) begin
               if (first_k < 0) first_k = j;
               bad_lines++;
            end
         end
      join
      n_checks++; if (bad_lines !== 0) begin n_fail++; $display("FAIL stall_stream_data: got %0d bad lines (first %0d) expected 0", bad_lines, first_k); end
      n_checks++; if (tout !== 0) begin n_fail++; $display("FAIL stall_stream_timeout: got %0d expected 0", tout); end
      n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL stall_stream_underrun: got %b expected 0", underrun); end
   endtask

   task automatic test_reset_mid_line();
      int w, bad, fx; logic [23:0] fg, fe;
      write_line(H, 24'h600000, 0, w);
      cyc(); cyc();
      for (int x = 0; x < 300; x++) begin
         video_active = 1'b1;
         pixel_x      = 10'(x);
         cyc();
      end
      n_checks++; if ({red, green, blue} !== 24'h60012B) begin n_fail++; $display("FAIL mid_line_data: got %h expected 60012b", {red, green, blue}); end
      rst_n = 1'b0; pixel_x = 10'd300;
      cyc();
      n_checks++; if ({red, green, blue} !== 24'h0) begin n_fail++; $display("FAIL mid_reset_rgb: got %h expected 000000", {red, green, blue}); end
      n_checks++; if (de_out !== 1'b0) begin n_fail++; $display("FAIL mid_reset_de: got %b expected 0", de_out); end
      n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_wr_ready: got %b expected 0", wr_ready); end
      video_active = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      run_line(4, 0, 24'h0, 1'b0, 1'b0, bad, fx, fg, fe);
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL post_reset_line_bg: %0d bad px, first x=%0d got %h expected %h", bad, fx, fg, fe); end
      n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL post_reset_underrun: got %b expected 1", underrun); end
      clr_status = 1'b1; cyc(); clr_status = 1'b0;
      n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL post_reset_clr: got %b expected 0", underrun); end
   endtask

   task automatic test_clr_set_wins();
      int bad, fx; logic [23:0] fg, fe;
      run_line(4, 0, 24'h0, 1'b0, 1'b1, bad, fx, fg, fe);
      n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL set_wins_underrun: got %b expected 1", underrun); end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL set_wins_line_bg: %0d bad px, first x=%0d got %h expected %h", bad, fx, fg, fe); end
   endtask

   initial begin
      test_reset();
      test_underrun_no_data();
      test_full_line();
      test_short_line();
      test_overflow();
      test_back_to_back();
      test_stalls();
      test_reset_mid_line();
      test_clr_set_wins();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
